mux_gate_pipe: RTL

//  Pipelined, parametrised logic-gate engine: every output bit is a 2-input function of a[i], b[i].

---
 rtl/mux_gate_pipe.sv | 136 +++++++++++++
 1 files changed

// File: rtl/mux_gate_pipe.sv
// Two-stage valid/ready gate engine: every result bit is a 2-input function of a[i], b[i],
// evaluated through a two-level 2:1 mux tree (b selects first, then a) over a 4-bit truth table.
module mux_gate_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_tt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [2:0]       out_op,
    output logic [CNT_W-1:0] op_count
);

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_NAND  = 3'd2;
    localparam logic [2:0] OP_NOR   = 3'd3;
    localparam logic [2:0] OP_XOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_NOT_A = 3'd6;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_a_reg;
    logic [WIDTH-1:0] s1_b_reg;
    logic [2:0]       s1_op_reg;
    logic [3:0]       s1_tt_reg;

    logic             out_valid_reg;
    logic [WIDTH-1:0] out_y_reg;
    logic [2:0]       out_op_reg;

    logic [3:0]       tt_reg;
    logic [CNT_W-1:0] op_count_reg;

    logic             s1_load;
    logic             s2_load;
    logic             in_accept;
    logic             out_fire;
    logic [3:0]       tt_next;
    logic [WIDTH-1:0] y_next;

    // S2 refills whenever it is empty or draining, so a full pipe still moves one beat per cycle.
    assign s2_load   = s1_valid_reg & (~out_valid_reg | out_ready);
    assign s1_load   = ~s1_valid_reg | s2_load;
    assign in_ready  = s1_load;
    assign in_accept = in_valid & s1_load;
    assign out_fire  = out_valid_reg & out_ready;

    // Truth table indexed by {a,b}; CUSTOM reads tt_reg before any same-cycle cfg_we lands.
    always_comb begin
        tt_next = tt_reg;
        case (in_op)
            OP_AND:   tt_next = 4'b1000;
            OP_OR:    tt_next = 4'b1110;
            OP_NAND:  tt_next = 4'b0111;
            OP_NOR:   tt_next = 4'b0001;
            OP_XOR:   tt_next = 4'b0110;
            OP_XNOR:  tt_next = 4'b1001;
            OP_NOT_A: tt_next = 4'b0011;
            default:  tt_next = tt_reg;
        endcase
    end

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            logic m0;
            logic m1;
            assign m0         = s1_b_reg[gi] ? s1_tt_reg[1] : s1_tt_reg[0];
            assign m1         = s1_b_reg[gi] ? s1_tt_reg[3] : s1_tt_reg[2];
            assign y_next[gi] = s1_a_reg[gi] ? m1 : m0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            s1_a_reg     <= '0;
            s1_b_reg     <= '0;
            s1_op_reg    <= '0;
            s1_tt_reg    <= '0;
        end else if (s1_load) begin
            s1_valid_reg <= in_valid;
            if (in_valid) begin
                s1_a_reg  <= in_a;
                s1_b_reg  <= in_b;
                s1_op_reg <= in_op;
                s1_tt_reg <= tt_next;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_y_reg     <= '0;
            out_op_reg    <= '0;
        end else if (s2_load) begin
            out_valid_reg <= 1'b1;
            out_y_reg     <= y_next;
            out_op_reg    <= s1_op_reg;
        end else if (out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tt_reg <= 4'b0000;
        end else if (cfg_we) begin
            tt_reg <= cfg_tt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_reg <= '0;
        end else if (out_fire && (op_count_reg != {CNT_W{1'b1}})) begin
            op_count_reg <= op_count_reg + 1'b1;
        end
    end

    assign out_valid = out_valid_reg;
    assign out_y     = out_y_reg;
    assign out_op    = out_op_reg;
    assign op_count  = op_count_reg;

endmodule
